ddr_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the controller's asynchronous write FIFO between `NUM_REQ` requesters (command, write-data and refresh/maintenance sources) in the write clock domain. It grants one requester at a time for a burst of up to `BURST_LEN` beats. It drives the FIFO's `w_en` and write data, and stalls on the FIFO's registered `full` flag.

---
 rtl/ddr_wr_arbiter_if.sv | 33 +++
 rtl/ddr_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_ddr_wr_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ddr_wr_arbiter_if.sv
// ddr_wr_arbiter_if: requester/FIFO-side signal bundle of the DDR write-port arbiter.
//   req       requester write requests, one bit per requester
//   wdata_in  packed requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   full      registered FIFO full flag
//   gnt       one-hot grant (registered)
//   ack       per-requester beat accepted this cycle
//   w_en      FIFO write enable
//   wdata     FIFO write data
//   busy      a grant is active
// Modports: master = arbiter side, slave = requesters/FIFO side.
interface ddr_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_in;
  logic                          full;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            ack;
  logic                          w_en;
  logic [DATA_WIDTH-1:0]         wdata;
  logic                          busy;

  modport master (
    input  req, wdata_in, full,
    output gnt, ack, w_en, wdata, busy
  );

  modport slave (
    output req, wdata_in, full,
    input  gnt, ack, w_en, wdata, busy
  );
endinterface

// File: rtl/ddr_wr_arbiter.sv
// ddr_wr_arbiter: round-robin arbiter sharing the async write FIFO's single
// write port between NUM_REQ requesters in the write clock domain.
// Ports:
//   wclk  write-domain clock
//   wrst  asynchronous active-high reset
//   bus   ddr_wr_arbiter_if.master (req, wdata_in, full in; gnt, ack, w_en, wdata, busy out)
// Build option: WR_ARB_BURST_LOCK_EN defined -> a grant is held for up to
// BURST_LEN beats; undefined -> the grant is released after every accepted beat.
module ddr_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  ddr_wr_arbiter_if.master      bus
);

  localparam int unsigned OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic {IDLE, BURST} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [OWN_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

  logic [OWN_W-1:0]      sel_idx;
  logic                  sel_found;
  logic [OWN_W-1:0]      cand;
  int unsigned           idx;
  logic                  req_own;
  logic                  last_beat;
  logic                  release_c;
  logic                  w_en_c;
  logic [NUM_REQ-1:0]    ack_c;
  logic [DATA_WIDTH-1:0] wdata_c;

  // State register
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_q       <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state and write-port outputs
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    beat_cnt_d = beat_cnt_q;
    sel_idx    = rr_q;
    sel_found  = 1'b0;
    cand       = '0;
    idx        = 0;
    wdata_c    = '0;

    // First requesting index at or above rr_q, wrapping modulo NUM_REQ
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = OWN_W'(idx);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end

    req_own = bus.req[owner_q];
    // State is cleared asynchronously, so w_en drops the moment wrst rises
    w_en_c  = (state_q == BURST) && req_own && !bus.full;
    ack_c   = gnt_q & {NUM_REQ{w_en_c}};

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if ((gnt_q != '0) && (owner_q == OWN_W'(i))) begin
        wdata_c = bus.wdata_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

`ifdef WR_ARB_BURST_LOCK_EN
    last_beat = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
`else
    last_beat = 1'b1;
`endif
    // A full stall (w_en=0 with req held) never releases the grant
    release_c = (w_en_c && last_beat) || !req_own;

    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          gnt_d      = NUM_REQ'(1) << sel_idx;
          owner_d    = sel_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (w_en_c) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        if (release_c) begin
          gnt_d   = '0;
          rr_d    = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + OWN_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_c;
  assign bus.w_en  = w_en_c;
  assign bus.wdata = wdata_c;
  assign bus.busy  = (state_q == BURST);

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// tb_ddr_wr_arbiter: table-driven check of ddr_wr_arbiter (NUM_REQ=4,
// DATA_WIDTH=8, BURST_LEN=4) plus a hand-written mid-burst reset sequence.
// Follows WR_ARB_BURST_LOCK_EN the same way the design does.
module tb_ddr_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;
`ifdef WR_ARB_BURST_LOCK_EN
  localparam int BL_EXP = 4;
  localparam int PULSE_BEAT = 3;
`else
  localparam int BL_EXP = 1;
  localparam int PULSE_BEAT = 1;
`endif
  localparam logic [31:0] DIN = 32'hD3C2B1A0;

  typedef struct {
    logic [3:0]  req;
    logic        full;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        wen;
    logic [7:0]  wdata;
    logic        busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vq[$];

  ddr_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  ddr_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .wclk (clk),
    .wrst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  function automatic void add(input int n, input logic [3:0] r, input logic f,
                              input logic [31:0] d, input logic [3:0] g,
                              input logic [3:0] a, input logic w,
                              input logic [7:0] wd, input logic b);
    for (int k = 0; k < n; k++) vq.push_back('{r, f, d, g, a, w, wd, b});
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " gnt"},   32'(bus.gnt),   32'h0);
    chk({tag, " ack"},   32'(bus.ack),   32'h0);
    chk({tag, " w_en"},  32'(bus.w_en),  32'h0);
    chk({tag, " wdata"}, 32'(bus.wdata), 32'h0);
    chk({tag, " busy"},  32'(bus.busy),  32'h0);
  endtask

  initial begin
    int acks;
    int cyc;

`ifdef WR_ARB_BURST_LOCK_EN
    add(1, 4'b0000, 0, DIN,          4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b0001, 0, DIN,          4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b0001, 0, 32'hD3C2B1A0, 4'b0001, 4'b0001, 1, 8'hA0, 1);
    add(1, 4'b0001, 0, 32'hD3C2B1A1, 4'b0001, 4'b0001, 1, 8'hA1, 1);
    add(1, 4'b0001, 0, 32'hD3C2B1A2, 4'b0001, 4'b0001, 1, 8'hA2, 1);
    add(1, 4'b0001, 0, 32'hD3C2B1A3, 4'b0001, 4'b0001, 1, 8'hA3, 1);
    add(1, 4'b0000, 0, DIN,          4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b0011, 0, DIN,          4'b0000, 4'b0000, 0, 8'h00, 0);
    add(4, 4'b0011, 0, DIN,          4'b0010, 4'b0010, 1, 8'hB1, 1);
    add(1, 4'b0011, 0, DIN,          4'b0000, 4'b0000, 0, 8'h00, 0);
    add(4, 4'b0011, 0, DIN,          4'b0001, 4'b0001, 1, 8'hA0, 1);
    add(1, 4'b0011, 0, DIN,          4'b0000, 4'b0000, 0, 8'h00, 0);
    add(2, 4'b0011, 0, DIN,          4'b0010, 4'b0010, 1, 8'hB1, 1);
    add(3, 4'b0011, 1, DIN,          4'b0010, 4'b0000, 0, 8'hB1, 1);
    add(2, 4'b0011, 0, DIN,          4'b0010, 4'b0010, 1, 8'hB1, 1);
    add(1, 4'b0100, 0, DIN,          4'b0000, 4'b0000, 0, 8'h00, 0);
    add(2, 4'b0100, 0, DIN,          4'b0100, 4'b0100, 1, 8'hC2, 1);
    add(1, 4'b0000, 0, DIN,          4'b0100, 4'b0000, 0, 8'hC2, 1);
    add(1, 4'b1111, 0, DIN,          4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b1111, 0, DIN,          4'b1000, 4'b1000, 1, 8'hD3, 1);
    add(1, 4'b0000, 0, DIN,          4'b1000, 4'b0000, 0, 8'hD3, 1);
    add(1, 4'b0000, 0, DIN,          4'b0000, 4'b0000, 0, 8'h00, 0);
`else
    add(1, 4'b0000, 0, DIN, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b0011, 0, DIN, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b0011, 0, DIN, 4'b0001, 4'b0001, 1, 8'hA0, 1);
    add(1, 4'b0011, 0, DIN, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b0011, 0, DIN, 4'b0010, 4'b0010, 1, 8'hB1, 1);
    add(1, 4'b0011, 0, DIN, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b0011, 0, DIN, 4'b0001, 4'b0001, 1, 8'hA0, 1);
    add(1, 4'b0011, 1, DIN, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(2, 4'b0011, 1, DIN, 4'b0010, 4'b0000, 0, 8'hB1, 1);
    add(1, 4'b0011, 0, DIN, 4'b0010, 4'b0010, 1, 8'hB1, 1);
    add(1, 4'b0100, 0, DIN, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b0000, 0, DIN, 4'b0100, 4'b0000, 0, 8'hC2, 1);
    add(1, 4'b1111, 0, DIN, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b1111, 0, DIN, 4'b1000, 4'b1000, 1, 8'hD3, 1);
    add(1, 4'b1111, 0, DIN, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b0000, 0, DIN, 4'b0001, 4'b0000, 0, 8'hA0, 1);
    add(2, 4'b0000, 0, DIN, 4'b0000, 4'b0000, 0, 8'h00, 0);
`endif

    // Reset values, including with every requester asserting
    rst = 1'b1;
    bus.req = '0;
    bus.full = 1'b0;
    bus.wdata_in = DIN;
    #2;
    chk_idle_outputs("reset");
    bus.req = 4'b1111;
    #1;
    chk_idle_outputs("reset req");
    #5;
    bus.req = '0;
    rst = 1'b0;

    // Vector table: drive after an edge, check mid-cycle
    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      bus.req      = vq[i].req;
      bus.full     = vq[i].full;
      bus.wdata_in = vq[i].din;
      #3;
      chk($sformatf("v%0d gnt", i),   32'(bus.gnt),   32'(vq[i].gnt));
      chk($sformatf("v%0d ack", i),   32'(bus.ack),   32'(vq[i].ack));
      chk($sformatf("v%0d w_en", i),  32'(bus.w_en),  32'(vq[i].wen));
      chk($sformatf("v%0d wdata", i), 32'(bus.wdata), 32'(vq[i].wdata));
      chk($sformatf("v%0d busy", i),  32'(bus.busy),  32'(vq[i].busy));
    end

    // Reset pulsed mid-burst, then a fresh grant of requester 2
    @(posedge clk);
    #1;
    bus.req = 4'b0100;
    bus.full = 1'b0;
    bus.wdata_in = DIN;
    @(posedge clk);
    #1;
    for (int b = 1; b < PULSE_BEAT; b++) begin
      @(posedge clk);
      #1;
    end
    chk("pre-rst gnt",  32'(bus.gnt),  32'h4);
    chk("pre-rst w_en", 32'(bus.w_en), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_outputs("mid-rst");
    @(posedge clk);
    #1;
    chk("rst held w_en", 32'(bus.w_en), 32'h0);
    chk("rst held busy", 32'(bus.busy), 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("post-rst idle gnt", 32'(bus.gnt), 32'h0);
    @(posedge clk);
    #1;
    chk("regrant gnt", 32'(bus.gnt), 32'h4);
    acks = bus.ack[2] ? 1 : 0;
    cyc = 0;
    while (bus.gnt != 4'b0000 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.ack[2]) acks++;
    end
    chk("regrant released", 32'(bus.gnt == 4'b0000), 32'h1);
    chk("regrant beats",    32'(acks),                32'(BL_EXP));
    bus.req = '0;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
